// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the digit scan sequencer.
// Imported by the interface, the index finder and the top level.
package scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_BLANK
    } state_t;

    localparam int SEL_W   = 3;
    localparam int NUM_DIG = 8;

    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b01;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control and decoder-drive bundle of the scan sequencer.
// master = scan controller, slave = sequencer.
interface scan_sequencer_if;
    import scan_sequencer_pkg::*;

    logic               iStart;
    logic               iStop;
    logic               iMode;
    logic [NUM_DIG-1:0] iMask;
    logic [SEL_W-1:0]   oSel;
    logic [1:0]         oEna;
    logic               oBusy;
    logic               oDone;
    logic               oWrap;

    modport master (
        output iStart, iStop, iMode, iMask,
        input  oSel, oEna, oBusy, oDone, oWrap
    );

    modport slave (
        input  iStart, iStop, iMode, iMask,
        output oSel, oEna, oBusy, oDone, oWrap
    );

endinterface

// File: rtl/scan_sequencer_mask_next_idx.sv
// Rotating priority finder: first set mask bit above cur, modulo 8.
// wrap flags that the search passed index 7; none flags an empty mask.
module mask_next_idx
    import scan_sequencer_pkg::*;
(
    input  logic [SEL_W-1:0]   cur,
    input  logic [NUM_DIG-1:0] mask,
    output logic [SEL_W-1:0]   nxt,
    output logic               wrap,
    output logic               none
);

    logic [SEL_W:0] w_sum;

    // Descending offsets so the nearest hit is the last assignment.
    always_comb begin
        nxt   = cur;
        wrap  = 1'b0;
        none  = 1'b1;
        w_sum = '0;
        for (int k = NUM_DIG; k >= 1; k--) begin
            w_sum = {1'b0, cur} + (SEL_W + 1)'(k);
            if (mask[w_sum[SEL_W-1:0]]) begin
                nxt  = w_sum[SEL_W-1:0];
                wrap = w_sum[SEL_W];
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a decoder select through enabled digits,
// holding each for a dwell time and blanking between digits.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int DWELL_CYCLES = 4000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input logic iClk,
    input logic iRst_n,
    scan_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] DWELL_LAST =
        CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic NO_BLANK = (BLANK_CYCLES == 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel;
    logic [1:0]       r_ena;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;
    logic             r_mode;

    logic [SEL_W-1:0] w_start_idx;
    logic             w_start_wrap;
    logic             w_start_none;
    logic [SEL_W-1:0] w_adv_idx;
    logic             w_adv_wrap;
    logic             w_adv_none;
    logic             w_start_ok;
    logic             w_adv;

    // Searching up from 7 yields the lowest enabled digit.
    mask_next_idx u_start_idx (
        .cur  (3'd7),
        .mask (bus.iMask),
        .nxt  (w_start_idx),
        .wrap (w_start_wrap),
        .none (w_start_none)
    );

    mask_next_idx u_adv_idx (
        .cur  (r_sel),
        .mask (bus.iMask),
        .nxt  (w_adv_idx),
        .wrap (w_adv_wrap),
        .none (w_adv_none)
    );

    assign w_start_ok = w_start_wrap & ~w_start_none;

    assign w_adv =
        ((r_state == ST_DWELL) && (r_cnt == DWELL_LAST) && NO_BLANK) ||
        ((r_state == ST_BLANK) && (r_cnt == BLANK_LAST));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_ena   <= ENA_OFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_mode  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.iStop) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_ena   <= ENA_OFF;
                r_busy  <= 1'b0;
            end else if (w_adv) begin
                r_cnt <= '0;
                if (w_adv_none || (w_adv_wrap && !r_mode)) begin
                    r_state <= ST_IDLE;
                    r_ena   <= ENA_OFF;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_wrap  <= w_adv_wrap & ~w_adv_none;
                end else begin
                    r_state <= ST_DWELL;
                    r_sel   <= w_adv_idx;
                    r_ena   <= ENA_ON;
                    r_wrap  <= w_adv_wrap;
                end
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.iStart && w_start_ok) begin
                            r_state <= ST_DWELL;
                            r_cnt   <= '0;
                            r_sel   <= w_start_idx;
                            r_ena   <= ENA_ON;
                            r_busy  <= 1'b1;
                            r_mode  <= bus.iMode;
                        end
                    end
                    ST_DWELL: begin
                        if (r_cnt == DWELL_LAST) begin
                            r_state <= ST_BLANK;
                            r_cnt   <= '0;
                            r_ena   <= ENA_OFF;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ena   <= ENA_OFF;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.oSel  = r_sel;
    assign bus.oEna  = r_ena;
    assign bus.oBusy = r_busy;
    assign bus.oDone = r_done;
    assign bus.oWrap = r_wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: two sequencers (blank 2 and blank 0) share stimulus;
// a digit-level plan model predicts each cycle's decoder outputs.
module tb_scan_sequencer;

    localparam int DW = 4;

    typedef struct {
        logic [2:0] sel;
        bit         sel_chk;
        logic [1:0] ena;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t qa[$];
    exp_t qb[$];

    scan_sequencer_if ifa ();
    scan_sequencer_if ifb ();

    scan_sequencer #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (2),
        .CNT_W        (16)
    ) dut_a (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (ifa.slave)
    );

    scan_sequencer #(
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (0),
        .CNT_W        (16)
    ) dut_b (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pk(exp_t e);
        return {e.sel, e.ena, e.busy, e.done, e.wrap};
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act,
                       input logic [7:0] exp, input logic [7:0] msk);
        checks++;
        if ((act & msk) !== (exp & msk)) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b care=%b",
                     nm, $time, act, exp, msk);
        end
    endtask

    function automatic exp_t idle_e(logic [2:0] s, bit chk);
        exp_t e;
        e.sel = s;
        e.sel_chk = chk;
        e.ena = 2'b01;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.wrap = 1'b0;
        return e;
    endfunction

    // Plan-level model: list digit visits, then expand to cycles.
    task automatic gen(input int nb, input bit mode,
                       input logic [7:0] m0, input int c,
                       input logic [7:0] m1, input int k,
                       output exp_t tr[$]);
        exp_t e;
        int d, t, nd;
        bit pw, fin, wr;
        logic [7:0] m;
        tr.delete();
        if (m0 != 8'h00) begin
            d = 0;
            while (!m0[d]) d++;
            t = 0; pw = 0; fin = 0;
            while (!fin && t < 400) begin
                for (int i = 0; i < DW + nb; i++) begin
                    e = idle_e(3'(d), 1'b1);
                    e.busy = 1'b1;
                    if (i < DW) e.ena = 2'b10;
                    e.wrap = (i == 0) && pw;
                    tr.push_back(e);
                    t++;
                end
                m = (t >= c) ? m1 : m0;
                nd = -1; wr = 0;
                for (int j = 8; j >= 1; j--) begin
                    if (m[(d + j) % 8]) begin
                        nd = (d + j) % 8;
                        wr = (d + j) >= 8;
                    end
                end
                pw = 0;
                if (nd < 0 || (wr && !mode)) begin
                    e = idle_e(3'(d), 1'b0);
                    e.done = 1'b1;
                    e.wrap = (nd >= 0);
                    tr.push_back(e);
                    fin = 1;
                end else begin
                    pw = wr;
                    d = nd;
                end
            end
        end
        if (k > 0 && k < tr.size()) begin
            e = idle_e(tr[k-1].sel, 1'b1);
            while (tr.size() > k) void'(tr.pop_back());
            tr.push_back(e);
        end
    endtask

    task automatic pad(inout exp_t tr[$], input int n);
        exp_t e;
        if (tr.size() > 0) e = idle_e(tr[$].sel, tr[$].sel_chk);
        else e = idle_e(3'd0, 1'b0);
        while (tr.size() < n) tr.push_back(e);
    endtask

    task automatic drv(input bit s, input bit p, input bit md,
                       input logic [7:0] m);
        ifa.iStart = s; ifa.iStop = p; ifa.iMode = md; ifa.iMask = m;
        ifb.iStart = s; ifb.iStop = p; ifb.iMode = md; ifb.iMask = m;
    endtask

    task automatic push_idle(input int n, input bit chk,
                             input logic [2:0] s);
        for (int i = 0; i < n; i++) begin
            qa.push_back(idle_e(s, chk));
            qb.push_back(idle_e(s, chk));
        end
    endtask

    task automatic drain_chk(input string nm);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain left=%0d/%0d required=0",
                     nm, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic run(input bit mode, input logic [7:0] m0,
                       input int c, input logic [7:0] m1,
                       input int k, input int s2);
        exp_t ta[$];
        exp_t tb[$];
        int n;
        bit st;
        gen(2, mode, m0, c, m1, k, ta);
        gen(0, mode, m0, c, m1, k, tb);
        n = ((ta.size() > tb.size()) ? ta.size() : tb.size()) + 3;
        pad(ta, n);
        pad(tb, n);
        @(negedge clk);
        foreach (ta[i]) qa.push_back(ta[i]);
        foreach (tb[i]) qb.push_back(tb[i]);
        drv(1'b1, 1'b0, mode, m0);
        for (int e = 1; e < n; e++) begin
            @(negedge clk);
            st = (e == s2) && ta[e-1].busy && tb[e-1].busy;
            drv(st, e == k, mode, (e >= c) ? m1 : m0);
        end
        @(negedge clk);
        drv(1'b0, 1'b0, mode, (n >= c) ? m1 : m0);
        drain_chk("run");
    endtask

    // Monitor: one expected entry per clock while the queue is loaded.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    cmp("A_out", {ifa.oSel, ifa.oEna, ifa.oBusy,
                        ifa.oDone, ifa.oWrap}, pk(e),
                        e.sel_chk ? 8'hFF : 8'h1F);
                end else begin
                    cmp("A_quiet", {6'd0, ifa.oDone, ifa.oWrap},
                        8'h00, 8'h03);
                end
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    cmp("B_out", {ifb.oSel, ifb.oEna, ifb.oBusy,
                        ifb.oDone, ifb.oWrap}, pk(e),
                        e.sel_chk ? 8'hFF : 8'h1F);
                end else begin
                    cmp("B_quiet", {6'd0, ifb.oDone, ifb.oWrap},
                        8'h00, 8'h03);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit md;
        logic [7:0] m0, m1;
        int c, k;
        errors = 0;
        checks = 0;
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp("A_reset", {ifa.oSel, ifa.oEna, ifa.oBusy, ifa.oDone,
            ifa.oWrap}, 8'b000_01_000, 8'hFF);
        cmp("B_reset", {ifb.oSel, ifb.oEna, ifb.oBusy, ifb.oDone,
            ifb.oWrap}, 8'b000_01_000, 8'hFF);
        rst_n = 1'b1;
        push_idle(3, 1'b1, 3'd0);
        repeat (3) @(negedge clk);
        drain_chk("post_reset");

        // Asynchronous reset in the middle of digit 4's dwell.
        drv(1'b1, 1'b0, 1'b0, 8'hF0);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b0, 8'hF0);
        @(negedge clk);
        cmp("A_pre_rst", {ifa.oSel, ifa.oEna, ifa.oBusy, 2'b00},
            8'b100_10_100, 8'hFF);
        rst_n = 1'b0;
        #1;
        cmp("A_mid_rst", {ifa.oSel, ifa.oEna, ifa.oBusy, ifa.oDone,
            ifa.oWrap}, 8'b000_01_000, 8'hFF);
        cmp("B_mid_rst", {ifb.oSel, ifb.oEna, ifb.oBusy, ifb.oDone,
            ifb.oWrap}, 8'b000_01_000, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(3, 1'b1, 3'd0);
        repeat (3) @(negedge clk);
        drain_chk("rst_idle");

        run(1'b0, 8'hFF, 1 << 20, 8'hFF, -1, 10);
        run(1'b1, 8'b1010_0100, 1 << 20, 8'h00, 45, -1);
        run(1'b1, 8'h08, 1 << 20, 8'h00, 26, 7);
        run(1'b0, 8'hFF, 1 << 20, 8'hFF, 26, -1);
        run(1'b1, 8'h0F, 8, 8'h00, -1, -1);
        run(1'b0, 8'h00, 1 << 20, 8'h00, -1, -1);

        // Start and stop together while idle.
        @(negedge clk);
        push_idle(3, 1'b0, 3'd0);
        drv(1'b1, 1'b1, 1'b0, 8'hFF);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b0, 8'hFF);
        repeat (2) @(negedge clk);
        drain_chk("start_stop");

        for (int r = 0; r < 14; r++) begin
            md = 1'($urandom % 2);
            m0 = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
            c  = ($urandom % 2) ? int'($urandom_range(1, 60)) : 1 << 20;
            m1 = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            if (md) k = int'($urandom_range(5, 120));
            else k = ($urandom % 2) ? int'($urandom_range(1, 60)) : -1;
            run(md, m0, c, m1, k, int'($urandom_range(1, 30)));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
